// File: rtl/cacheline_adapter_pkg.sv
// Shared types and constants for the cache dfp-to-bmem line adapter.
package cacheline_adapter_pkg;

    localparam int LINE_W = 256;
    localparam int BEAT_W = 64;
    localparam int BEATS  = LINE_W / BEAT_W;
    localparam int TAG_W  = 27;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_BEAT  = 3'd3,
        ST_RESP     = 3'd4
    } adapter_state_t;

    // Line-aligned byte address for a registered line tag.
    function automatic logic [31:0] line_base(input logic [TAG_W-1:0] tag);
        return {tag, 5'b00000};
    endfunction

endpackage

// File: rtl/cacheline_adapter_line_beat_buffer.sv
// 256-bit line register with whole-line load and 64-bit beat write/select.
// Used both to assemble read beats and to serialize a write line.
module line_beat_buffer
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [LINE_W-1:0] load_line,
    input  logic              beat_we,
    input  logic [1:0]        beat_idx,
    input  logic [BEAT_W-1:0] beat_wdata,
    input  logic [1:0]        sel_idx,
    output logic [BEAT_W-1:0] sel_data,
    output logic [LINE_W-1:0] line
);

    logic [LINE_W-1:0] line_d;
    logic [LINE_W-1:0] line_q;

    // Next line contents: full load wins over a single beat write.
    always_comb begin
        line_d = line_q;
        if (load_en) begin
            line_d = load_line;
        end else if (beat_we) begin
            line_d[{beat_idx, 6'b000000} +: BEAT_W] = beat_wdata;
        end else begin
            line_d = line_q;
        end
    end

    // Line storage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign sel_data = line_q[{sel_idx, 6'b000000} +: BEAT_W];
    assign line     = line_q;

endmodule

// File: rtl/cacheline_adapter.sv
// Cache dfp line port to 4-beat bmem burst adapter.
// Optional protocol checker enabled by defining CACHELINE_ADAPTER_CHECK_EN;
// without it proto_err is tied low and no checker logic exists.
module cacheline_adapter
    import cacheline_adapter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dfp_addr,
    input  logic              dfp_read,
    input  logic              dfp_write,
    input  logic [LINE_W-1:0] dfp_wdata,
    output logic [LINE_W-1:0] dfp_rdata,
    output logic              dfp_resp,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [BEAT_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [BEAT_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid,
    output logic              proto_err
);

    adapter_state_t    state_d, state_q;
    logic [1:0]        cnt_d, cnt_q;
    logic [TAG_W-1:0]  tag_d, tag_q;
    logic              started_d, started_q;
    logic [LINE_W-1:0] rdata_d, rdata_q;

    logic              buf_load_s;
    logic              buf_we_s;
    logic [BEAT_W-1:0] buf_sel_s;
    logic [LINE_W-1:0] buf_line_s;
    logic              unused_s;

    line_beat_buffer u_buf (
        .clk        (clk),
        .rst        (rst),
        .load_en    (buf_load_s),
        .load_line  (dfp_wdata),
        .beat_we    (buf_we_s),
        .beat_idx   (cnt_q),
        .beat_wdata (bmem_rdata),
        .sel_idx    (cnt_q),
        .sel_data   (buf_sel_s),
        .line       (buf_line_s)
    );

    // Next-state, beat counting and bmem/dfp output decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        started_d  = started_q;
        rdata_d    = rdata_q;
        buf_load_s = 1'b0;
        buf_we_s   = 1'b0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = 32'h0000_0000;
        dfp_resp   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dfp_write) begin
                    state_d    = ST_WR_BEAT;
                    tag_d      = dfp_addr[31:5];
                    cnt_d      = 2'd0;
                    started_d  = 1'b0;
                    buf_load_s = 1'b1;
                end else if (dfp_read) begin
                    state_d = ST_RD_ISSUE;
                    tag_d   = dfp_addr[31:5];
                    cnt_d   = 2'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ISSUE: begin
                bmem_read = 1'b1;
                bmem_addr = line_base(tag_q);
                if (bmem_ready) begin
                    state_d = ST_RD_WAIT;
                end else begin
                    state_d = ST_RD_ISSUE;
                end
            end
            ST_RD_WAIT: begin
                bmem_addr = line_base(tag_q);
                // Only beats tagged with our line address are accepted.
                if (bmem_rvalid && (bmem_raddr == line_base(tag_q))) begin
                    buf_we_s = 1'b1;
                    cnt_d    = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = ST_RESP;
                        rdata_d = {bmem_rdata, buf_line_s[3*BEAT_W-1:0]};
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end else begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_WR_BEAT: begin
                bmem_addr = line_base(tag_q);
                // Ready gates only the first beat; the rest stream back-to-back.
                if (started_q || bmem_ready) begin
                    bmem_write = 1'b1;
                    started_d  = 1'b1;
                    cnt_d      = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d   = ST_RESP;
                        started_d = 1'b0;
                    end else begin
                        state_d = ST_WR_BEAT;
                    end
                end else begin
                    state_d = ST_WR_BEAT;
                end
            end
            ST_RESP: begin
                dfp_resp = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and read-result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 2'd0;
            tag_q     <= '0;
            started_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            started_q <= started_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bmem_wdata = bmem_write ? buf_sel_s : 64'h0;
    assign dfp_rdata  = rdata_q;
    assign unused_s   = ^{dfp_addr[4:0], buf_line_s[LINE_W-1:3*BEAT_W]};

`ifdef CACHELINE_ADAPTER_CHECK_EN
    logic proto_err_d, proto_err_q;

    // Sticky detection of requester and memory protocol violations.
    always_comb begin
        proto_err_d = proto_err_q;
        if ((state_q == ST_IDLE) && dfp_read && dfp_write) begin
            proto_err_d = 1'b1;
        end else if ((state_q != ST_IDLE) && (dfp_read || dfp_write) &&
                     (dfp_addr[31:5] != tag_q)) begin
            proto_err_d = 1'b1;
        end else if (bmem_rvalid && (state_q != ST_RD_WAIT)) begin
            proto_err_d = 1'b1;
        end else if (bmem_rvalid && (state_q == ST_RD_WAIT) &&
                     (bmem_raddr != line_base(tag_q))) begin
            proto_err_d = 1'b1;
        end else begin
            proto_err_d = proto_err_q;
        end
    end

    // Protocol error flag register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed self-checking bench for cacheline_adapter.
module tb_cacheline_adapter;

    logic         clk;
    logic         rst;
    logic [31:0]  dfp_addr;
    logic         dfp_read;
    logic         dfp_write;
    logic [255:0] dfp_wdata;
    logic [255:0] dfp_rdata;
    logic         dfp_resp;
    logic [31:0]  bmem_addr;
    logic         bmem_read;
    logic         bmem_write;
    logic [63:0]  bmem_wdata;
    logic         bmem_ready;
    logic [31:0]  bmem_raddr;
    logic [63:0]  bmem_rdata;
    logic         bmem_rvalid;
    logic         proto_err;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int rd_pulses = 0;
    int wr_beats  = 0;
    int resp_cnt  = 0;
    int base_rd, base_wr, base_resp;
    logic exp_perr;

    cacheline_adapter dut (
        .clk         (clk),
        .rst         (rst),
        .dfp_addr    (dfp_addr),
        .dfp_read    (dfp_read),
        .dfp_write   (dfp_write),
        .dfp_wdata   (dfp_wdata),
        .dfp_rdata   (dfp_rdata),
        .dfp_resp    (dfp_resp),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_write  (bmem_write),
        .bmem_wdata  (bmem_wdata),
        .bmem_ready  (bmem_ready),
        .bmem_raddr  (bmem_raddr),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid),
        .proto_err   (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count bus events at each active edge.
    always @(posedge clk) begin
        if (!rst) begin
            rd_pulses <= rd_pulses + (bmem_read ? 1 : 0);
            wr_beats  <= wr_beats + (bmem_write ? 1 : 0);
            resp_cnt  <= resp_cnt + (dfp_resp ? 1 : 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic beat(input logic [31:0] ra, input logic [63:0] rd);
        bmem_rvalid = 1'b1;
        bmem_raddr  = ra;
        bmem_rdata  = rd;
        tick();
        bmem_rvalid = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_resp"},  {255'd0, dfp_resp},   256'd0);
        check({tag, "_rdata"}, dfp_rdata,            256'd0);
        check({tag, "_rd"},    {255'd0, bmem_read},  256'd0);
        check({tag, "_wr"},    {255'd0, bmem_write}, 256'd0);
        check({tag, "_addr"},  {224'd0, bmem_addr},  256'd0);
        check({tag, "_wdata"}, {192'd0, bmem_wdata}, 256'd0);
        check({tag, "_perr"},  {255'd0, proto_err},  256'd0);
    endtask

    initial begin
`ifdef CACHELINE_ADAPTER_CHECK_EN
        exp_perr = 1'b1;
`else
        exp_perr = 1'b0;
`endif
        rst = 1'b1; dfp_addr = 32'h0; dfp_read = 1'b0; dfp_write = 1'b0;
        dfp_wdata = 256'h0; bmem_ready = 1'b1; bmem_raddr = 32'h0;
        bmem_rdata = 64'h0; bmem_rvalid = 1'b0;
        tick(); tick();
        check_idle_outputs("reset");
        rst = 1'b0;
        tick();

        // Read at 0x1234 with a stray beat mid-burst.
        base_rd = rd_pulses; base_resp = resp_cnt;
        dfp_addr = 32'h0000_1234; dfp_read = 1'b1;
        #1;
        check("rd_idle_noread", {255'd0, bmem_read}, 256'd0);
        tick();
        check("rd_issue", {255'd0, bmem_read}, 256'd1);
        check("rd_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_1220});
        tick();
        check("rd_single_pulse", {255'd0, bmem_read}, 256'd0);
        beat(32'h0000_1220, 64'h0000_0000_0000_0000);
        beat(32'h0000_1220, 64'h1111_1111_1111_1111);
        beat(32'h0000_0999, 64'hBAD0_BAD0_BAD0_BAD0);
        beat(32'h0000_1220, 64'h2222_2222_2222_2222);
        check("rd_no_early_resp", {255'd0, dfp_resp}, 256'd0);
        beat(32'h0000_1220, 64'h3333_3333_3333_3333);
        check("rd_resp", {255'd0, dfp_resp}, 256'd1);
        check("rd_line", dfp_rdata, {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                     64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000});
        check("rd_stray_perr", {255'd0, proto_err}, {255'd0, exp_perr});
        dfp_read = 1'b0;
        tick();
        check("rd_resp_one_cycle", {255'd0, dfp_resp}, 256'd0);
        check("rd_line_hold", dfp_rdata, {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
                                          64'h1111_1111_1111_1111, 64'h0000_0000_0000_0000});
        check("rd_pulse_count", 256'(rd_pulses - base_rd), 256'd1);
        check("rd_resp_count", 256'(resp_cnt - base_resp), 256'd1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("perr_cleared", {255'd0, proto_err}, 256'd0);
        tick();

        // Write with ready low for three cycles, then an eviction read.
        base_rd = rd_pulses; base_wr = wr_beats; base_resp = resp_cnt;
        dfp_addr = 32'h0000_0040; dfp_write = 1'b1; bmem_ready = 1'b0;
        dfp_wdata = {64'hD, 64'hC, 64'hB, 64'hA};
        tick();
        check("wr_stall1", {255'd0, bmem_write}, 256'd0);
        tick();
        check("wr_stall2", {255'd0, bmem_write}, 256'd0);
        tick();
        check("wr_stall3", {255'd0, bmem_write}, 256'd0);
        bmem_ready = 1'b1;
        #1;
        check("wr_b0", {191'd0, bmem_write, bmem_wdata}, {191'd0, 1'b1, 64'hA});
        check("wr_addr", {224'd0, bmem_addr}, {224'd0, 32'h0000_0040});
        tick();
        bmem_ready = 1'b0;
        dfp_wdata = {256{1'b1}};
        #1;
        check("wr_b1", {191'd0, bmem_write, bmem_wdata}, {191'd0, 1'b1, 64'hB});
        tick();
        check("wr_b2", {191'd0, bmem_write, bmem_wdata}, {191'd0, 1'b1, 64'hC});
        tick();
        check("wr_b3", {191'd0, bmem_write, bmem_wdata}, {191'd0, 1'b1, 64'hD});
        tick();
        check("wr_resp", {255'd0, dfp_resp}, 256'd1);
        check("wr_done", {255'd0, bmem_write}, 256'd0);
        dfp_write = 1'b0; dfp_read = 1'b1; dfp_addr = 32'h0000_0080; bmem_ready = 1'b1;
        tick();
        check("ev_idle_resp", {255'd0, dfp_resp}, 256'd0);
        check("ev_idle_rd", {255'd0, bmem_read}, 256'd0);
        tick();
        check("ev_issue", {224'd0, bmem_addr}, {224'd0, 32'h0000_0080});
        tick();
        beat(32'h0000_0080, 64'h0123_4567_89AB_CDEF);
        beat(32'h0000_0080, 64'hFEDC_BA98_7654_3210);
        beat(32'h0000_0080, 64'hDEAD_BEEF_CAFE_F00D);
        beat(32'h0000_0080, 64'h0F0F_0F0F_0F0F_0F0F);
        check("ev_resp", {255'd0, dfp_resp}, 256'd1);
        check("ev_line", dfp_rdata, {64'h0F0F_0F0F_0F0F_0F0F, 64'hDEAD_BEEF_CAFE_F00D,
                                     64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF});
        dfp_read = 1'b0;
        tick();
        check("ev_resp_count", 256'(resp_cnt - base_resp), 256'd2);
        check("ev_rd_count", 256'(rd_pulses - base_rd), 256'd1);
        check("ev_wr_count", 256'(wr_beats - base_wr), 256'd4);

        // Reset in RD_WAIT after two beats, then a fresh read.
        dfp_addr = 32'h0000_0200; dfp_read = 1'b1;
        tick();
        tick();
        beat(32'h0000_0200, 64'hAAAA_0000_0000_0001);
        beat(32'h0000_0200, 64'hAAAA_0000_0000_0002);
        rst = 1'b1; dfp_read = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check_idle_outputs("midrst");
        base_resp = resp_cnt;
        dfp_addr = 32'h0000_0300; dfp_read = 1'b1;
        tick();
        check("rr_addr", {223'd0, bmem_read, bmem_addr}, {223'd0, 1'b1, 32'h0000_0300});
        tick();
        beat(32'h0000_0300, 64'h5555_0000_0000_0000);
        beat(32'h0000_0300, 64'h5555_0000_0000_0001);
        beat(32'h0000_0300, 64'h5555_0000_0000_0002);
        beat(32'h0000_0300, 64'h5555_0000_0000_0003);
        check("rr_resp", {255'd0, dfp_resp}, 256'd1);
        check("rr_line", dfp_rdata, {64'h5555_0000_0000_0003, 64'h5555_0000_0000_0002,
                                     64'h5555_0000_0000_0001, 64'h5555_0000_0000_0000});
        dfp_read = 1'b0;
        tick();
        check("rr_resp_count", 256'(resp_cnt - base_resp), 256'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
